axi_lite_wr_slave: RTL and testbench
====================================

AXI_LITE_WR_SLAVE -- requirements
Module: axi_lite_wr_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h40000000, base of the 16-byte register window.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), depth of the ID FIFO.
REQ-005 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 S_AXI_AWADDR  in  ADDR_WIDTH; S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1: write-address channel.
REQ-008 S_AXI_WDATA  in  DATA_WIDTH; S_AXI_WVALID  in  1; S_AXI_WREADY  out  1: write-data channel.
REQ-009 S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1: write-response channel.
REQ-010 ctrl_reg  out  DATA_WIDTH: CTRL register contents.
REQ-011 id_data  out  DATA_WIDTH; id_valid  out  1; id_ready  in  1: ID FIFO output stream (downstream consumer).
REQ-012 id_level  out  $clog2(FIFO_DEPTH)+1: FIFO occupancy.
REQ-013 ovf_count  out  8: dropped-ID count, saturating at 255.

Function
REQ-014 Register map (offset from BASE_ADDR): 0x0 CTRL (RW), 0x4 ID (push-on-write), 0x8 SCRATCH (RW, internal only), 0xC STATUS (read-only).
REQ-015 SHALL accept AW and W independently in either order or in the same cycle; each captured into its own holding register.
REQ-016 S_AXI_AWREADY SHALL be 1 only when no address is held and state is not RESP; S_AXI_WREADY likewise for data.
REQ-017 State machine: IDLE (capturing) -> WRITE (one cycle, both address and data held) -> RESP (S_AXI_BVALID=1) -> IDLE upon S_AXI_BVALID && S_AXI_BREADY.
REQ-018 Latency: from the cycle the later of AW/W handshakes, S_AXI_BVALID SHALL assert 2 cycles later (WRITE cycle, then RESP registered).
REQ-019 S_AXI_BVALID and S_AXI_BRESP SHALL stay stable until S_AXI_BREADY is sampled high; no new AW/W accepted during RESP.
REQ-020 BRESP = 2'b10 (SLVERR), with no state change, when: offset >= 0x10, AWADDR below BASE_ADDR, AWADDR[1:0] != 0, or target is STATUS; otherwise 2'b00.
REQ-021 Write to ID SHALL push WDATA into the FIFO in the WRITE cycle; if FIFO full and id_ready && id_valid is not asserted in that cycle, data is dropped, ovf_count increments (saturating) and BRESP = SLVERR.
REQ-022 Simultaneous push and pop on a full FIFO SHALL both succeed, occupancy unchanged, BRESP = OKAY.
REQ-023 id_valid = (id_level != 0); id_data = head entry; pop on id_valid && id_ready; no bypass: a push into an empty FIFO is visible on id_valid the following cycle.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; id_level ranges 0..FIFO_DEPTH.

Reset
REQ-025 On rst_n low, asynchronously: state IDLE, holding registers empty, S_AXI_AWREADY=0, S_AXI_WREADY=0, S_AXI_BVALID=0, S_AXI_BRESP=2'b00, ctrl_reg=0, SCRATCH=0, FIFO empty (id_valid=0, id_level=0), ovf_count=0.
REQ-026 S_AXI_AWREADY/S_AXI_WREADY SHALL first assert in the first cycle after rst_n deasserts.
REQ-027 Reset mid-transaction SHALL abandon it; no response issued, no register or FIFO update.

Configuration
REQ-028 Macro AXI_LITE_WR_SLAVE_SEQ_CHECK_EN: when defined, adds output seq_err (1 bit, reset 0), set sticky when an accepted ID push is not previous accepted ID + 1 (modulo 2^DATA_WIDTH); first push after reset never sets it; cleared by writing CTRL bit 31 = 1 (bit 31 stored as 0).
REQ-029 When not defined, seq_err port and logic SHALL be absent and CTRL bit 31 is an ordinary RW bit.

Verification
REQ-030 AW=0x40000004 then W=0x1230 three cycles later, BREADY=1 -> BVALID 2 cycles after W handshake, BRESP=00, id_valid=1 next cycle, id_data=0x1230.
REQ-031 AW and W same cycle to 0x40000000, data 0xA5A5A5A5 -> ctrl_reg=0xA5A5A5A5 after WRITE cycle, BRESP=00.
REQ-032 Writes to 0x4000000C, 0x40000010, 0x40000006 -> each BRESP=10, ctrl_reg and FIFO unchanged.
REQ-033 id_ready=0, five ID writes (FIFO_DEPTH=4) -> id_level=4, fifth BRESP=10, ovf_count=1; then drain -> IDs 1st..4th in order.
REQ-034 FIFO full, ID write with id_ready=1 in WRITE cycle -> BRESP=00, id_level stays 4, ovf_count unchanged.
REQ-035 With macro: IDs 0x1230, 0x1231, 0x1233 -> seq_err=1 after third; CTRL write 0x80000000 -> seq_err=0; rst_n low mid-RESP -> BVALID=0 immediately.

Source files
------------

// File: rtl/axi_lite_wr_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_wr_slave
// Write-only AXI4-Lite slave exposing a 16-byte register window at BASE_ADDR:
//   +0x0 CTRL    (RW, mirrored on ctrl_reg)
//   +0x4 ID      (write pushes WDATA into an ID FIFO drained via id_* stream)
//   +0x8 SCRATCH (RW, internal only)
//   +0xC STATUS  (read-only, writes answered with SLVERR)
// Optional build macro AXI_LITE_WR_SLAVE_SEQ_CHECK_EN adds seq_err, a sticky
// flag raised when an accepted ID is not the previous accepted ID + 1;
// writing CTRL with bit 31 set clears it, and CTRL bit 31 then always reads 0.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   S_AXI_AW*/S_AXI_W*/S_AXI_B*         AXI-Lite write address/data/response
//   ctrl_reg                            CTRL register contents
//   id_data, id_valid, id_ready         ID FIFO output stream
//   id_level                            FIFO occupancy (0..FIFO_DEPTH)
//   ovf_count                           dropped-ID counter, saturates at 255
//   seq_err                             (macro only) ID sequence error flag
// -----------------------------------------------------------------------------
module axi_lite_wr_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h40000000,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_WIDTH-1:0]         S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]         S_AXI_WDATA,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    output logic [DATA_WIDTH-1:0]         ctrl_reg,
    output logic [DATA_WIDTH-1:0]         id_data,
    output logic                          id_valid,
    input  logic                          id_ready,
    output logic [$clog2(FIFO_DEPTH):0]   id_level,
    output logic [7:0]                    ovf_count
`ifdef AXI_LITE_WR_SLAVE_SEQ_CHECK_EN
    ,
    output logic                          seq_err
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_RESP  = 2'b10
    } state_t;

    state_t                  state_q, state_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0]   ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0]   scratch_q, scratch_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic [7:0]              ovf_q, ovf_d;

    logic                    aw_hs_s, w_hs_s;
    logic [ADDR_WIDTH-1:0]   offset_s;
    logic                    addr_err_s;
    logic                    in_write_s;
    logic                    sel_ctrl_s, sel_id_s, sel_scr_s;
    logic                    pop_s, push_s, drop_s, full_s, id_wr_s;

    // Address decode of the held address and FIFO push/pop qualification.
    always_comb begin
        aw_hs_s    = S_AXI_AWVALID && awready_q;
        w_hs_s     = S_AXI_WVALID && wready_q;
        offset_s   = addr_q - BASE_ADDR;
        addr_err_s = (addr_q < BASE_ADDR) || (offset_s >= ADDR_WIDTH'(16)) ||
                     (addr_q[1:0] != 2'b00) || (offset_s[3:0] == 4'hC);
        in_write_s = (state_q == ST_WRITE);
        sel_ctrl_s = !addr_err_s && (offset_s[3:2] == 2'd0);
        sel_id_s   = !addr_err_s && (offset_s[3:2] == 2'd1);
        sel_scr_s  = !addr_err_s && (offset_s[3:2] == 2'd2);
        full_s     = (level_q == LW'(FIFO_DEPTH));
        pop_s      = (level_q != LW'(0)) && id_ready;
        id_wr_s    = in_write_s && sel_id_s;
        // A pop in the same cycle frees the slot a full FIFO needs.
        push_s     = id_wr_s && (!full_s || pop_s);
        drop_s     = id_wr_s && !push_s;
    end

    // Next-state logic for the write FSM, holding registers and registers.
    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        case (state_q)
            ST_IDLE: begin
                if (aw_hs_s) begin
                    aw_held_d = 1'b1;
                    addr_d    = S_AXI_AWADDR;
                end else begin
                    aw_held_d = aw_held_q;
                end
                if (w_hs_s) begin
                    w_held_d = 1'b1;
                    wdata_d  = S_AXI_WDATA;
                end else begin
                    w_held_d = w_held_q;
                end
                if (aw_held_d && w_held_d) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d   = ST_RESP;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                bvalid_d  = 1'b1;
                bresp_d   = (addr_err_s || drop_s) ? 2'b10 : 2'b00;
                if (sel_ctrl_s) begin
                    ctrl_d = wdata_q;
`ifdef AXI_LITE_WR_SLAVE_SEQ_CHECK_EN
                    // Bit 31 is a write-1-to-clear strobe for seq_err, never stored.
                    ctrl_d[31] = 1'b0;
`endif
                end else begin
                    ctrl_d = ctrl_q;
                end
                if (sel_scr_s) begin
                    scratch_d = wdata_q;
                end else begin
                    scratch_d = scratch_q;
                end
            end
            ST_RESP: begin
                if (S_AXI_BREADY) begin
                    state_d  = ST_IDLE;
                    bvalid_d = 1'b0;
                end else begin
                    state_d  = ST_RESP;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                bvalid_d  = 1'b0;
            end
        endcase
        // Ready flags are registered from the next state so they stay low in reset.
        awready_d = !aw_held_d && (state_d != ST_RESP);
        wready_d  = !w_held_d && (state_d != ST_RESP);
    end

    // FIFO storage, pointers, occupancy and overflow counter next-state.
    always_comb begin
        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = wdata_q;
        end else begin
            mem_d = mem_q;
        end
        wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        ovf_d = (drop_s && (ovf_q != 8'hFF)) ? (ovf_q + 8'd1) : ovf_q;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            ctrl_q    <= '0;
            scratch_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef AXI_LITE_WR_SLAVE_SEQ_CHECK_EN
    logic                  seq_err_q, seq_err_d;
    logic                  have_last_q, have_last_d;
    logic [DATA_WIDTH-1:0] last_id_q, last_id_d;

    // Sequence checker: compares each accepted ID with the previous one + 1.
    always_comb begin
        if (push_s) begin
            seq_err_d   = seq_err_q ||
                          (have_last_q && (wdata_q != (last_id_q + DATA_WIDTH'(1))));
            last_id_d   = wdata_q;
            have_last_d = 1'b1;
        end else if (in_write_s && sel_ctrl_s && wdata_q[31]) begin
            seq_err_d   = 1'b0;
            last_id_d   = last_id_q;
            have_last_d = have_last_q;
        end else begin
            seq_err_d   = seq_err_q;
            last_id_d   = last_id_q;
            have_last_d = have_last_q;
        end
    end

    // Sequence checker registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_err_q   <= 1'b0;
            have_last_q <= 1'b0;
            last_id_q   <= '0;
        end else begin
            seq_err_q   <= seq_err_d;
            have_last_q <= have_last_d;
            last_id_q   <= last_id_d;
        end
    end

    assign seq_err = seq_err_q;
`endif

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign ctrl_reg      = ctrl_q;
    assign id_data       = mem_q[rd_ptr_q];
    assign id_valid      = (level_q != LW'(0));
    assign id_level      = level_q;
    assign ovf_count     = ovf_q;

endmodule

// File: tb/tb_axi_lite_wr_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_wr_slave
// Directed plus randomized write traffic against axi_lite_wr_slave with default
// parameters. A behavioural model (register values, an ID queue, an overflow
// counter and the optional sequence flag) predicts responses and state.
// -----------------------------------------------------------------------------
module tb_axi_lite_wr_slave;

    localparam logic [31:0] BASE  = 32'h40000000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] S_AXI_AWADDR = 32'd0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = 32'd0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [31:0] ctrl_reg;
    logic [31:0] id_data;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [2:0]  id_level;
    logic [7:0]  ovf_count;
`ifdef AXI_LITE_WR_SLAVE_SEQ_CHECK_EN
    logic        seq_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] m_ctrl = 32'd0;
    int          m_ovf = 0;
    bit          m_have = 1'b0;
    logic [31:0] m_last = 32'd0;
    bit          m_seq = 1'b0;

    axi_lite_wr_slave dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .ctrl_reg      (ctrl_reg),
        .id_data       (id_data),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_level      (id_level),
        .ovf_count     (ovf_count)
`ifdef AXI_LITE_WR_SLAVE_SEQ_CHECK_EN
        ,
        .seq_err       (seq_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_ctrl = 32'd0;
        m_ovf  = 0;
        m_have = 1'b0;
        m_last = 32'd0;
        m_seq  = 1'b0;
    endfunction

    // Effect of one completed write; returns the expected BRESP.
    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input bit pop);
        logic [31:0] off;
        bit          bad;
        off = addr - BASE;
        if (pop && mq.size() > 0) void'(mq.pop_front());
        bad = (addr < BASE) || (off >= 32'd16) || (addr[1:0] != 2'b00) || (off == 32'd12);
        if (bad) return 2'b10;
        if (off == 32'd0) begin
            m_ctrl = data;
`ifdef AXI_LITE_WR_SLAVE_SEQ_CHECK_EN
            if (data[31]) m_seq = 1'b0;
            m_ctrl[31] = 1'b0;
`endif
            return 2'b00;
        end
        if (off == 32'd4) begin
            if (mq.size() >= DEPTH) begin
                if (m_ovf < 255) m_ovf++;
                return 2'b10;
            end
            if (m_have && data != m_last + 32'd1) m_seq = 1'b1;
            m_have = 1'b1;
            m_last = data;
            mq.push_back(data);
        end
        return 2'b00;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_ctrl"}, ctrl_reg, m_ctrl);
        chk({tag, "_level"}, id_level, mq.size());
        chk({tag, "_ovf"}, ovf_count, m_ovf);
`ifdef AXI_LITE_WR_SLAVE_SEQ_CHECK_EN
        chk({tag, "_seq_err"}, seq_err, m_seq);
`endif
    endtask

    // Asserts reset at the current time, checks reset values, releases it.
    task automatic do_reset();
        rst_n = 1'b0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        id_ready      = 1'b0;
        #1;
        model_reset();
        chk("rst_bvalid", S_AXI_BVALID, 1'b0);
        chk("rst_bresp", S_AXI_BRESP, 2'b00);
        chk("rst_awready", S_AXI_AWREADY, 1'b0);
        chk("rst_wready", S_AXI_WREADY, 1'b0);
        chk("rst_id_valid", id_valid, 1'b0);
        check_state("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_awready_lo", S_AXI_AWREADY, 1'b0);
        @(negedge clk);
        chk("rel_awready_hi", S_AXI_AWREADY, 1'b1);
        chk("rel_wready_hi", S_AXI_WREADY, 1'b1);
    endtask

    // One write: AW/W delays in cycles, BREADY delay after BVALID, id_ready in WRITE cycle.
    task automatic txn(input logic [31:0] addr, input logic [31:0] data, input int aw_dly,
                       input int w_dly, input int b_dly, input bit rdy_w);
        bit         aw_done, w_done;
        int         cyc;
        logic [1:0] exp_resp;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        chk("idle_awready", S_AXI_AWREADY, 1'b1);
        chk("idle_wready", S_AXI_WREADY, 1'b1);
        while (!(aw_done && w_done)) begin
            @(posedge clk);
            #1;
            S_AXI_AWADDR  = addr;
            S_AXI_WDATA   = data;
            S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            S_AXI_WVALID  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            if (aw_done) chk("held_awready", S_AXI_AWREADY, 1'b0);
            if (w_done) chk("held_wready", S_AXI_WREADY, 1'b0);
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1'b1;
            if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1'b1;
            cyc++;
            if (cyc > 20) begin
                checks++;
                errors++;
                $error("FAIL hs_timeout: observed no handshake expected handshake within 20 cycles");
                break;
            end
        end
        // WRITE cycle
        @(posedge clk);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        id_ready      = rdy_w;
        @(negedge clk);
        chk("write_bvalid", S_AXI_BVALID, 1'b0);
        chk("write_awready", S_AXI_AWREADY, 1'b0);
        chk("write_id_valid", id_valid, mq.size() != 0);
        if (mq.size() != 0) chk("write_id_data", id_data, mq[0]);
        exp_resp = model_write(addr, data, rdy_w);
        // First RESP cycle
        @(posedge clk);
        #1;
        id_ready     = 1'b0;
        S_AXI_BREADY = (b_dly == 0);
        @(negedge clk);
        chk("bvalid", S_AXI_BVALID, 1'b1);
        chk("bresp", S_AXI_BRESP, exp_resp);
        for (int i = 1; i <= b_dly; i++) begin
            @(posedge clk);
            #1 S_AXI_BREADY = (i == b_dly);
            @(negedge clk);
            chk("bvalid_hold", S_AXI_BVALID, 1'b1);
            chk("bresp_hold", S_AXI_BRESP, exp_resp);
        end
        @(posedge clk);
        #1 S_AXI_BREADY = 1'b0;
        @(negedge clk);
        chk("done_bvalid", S_AXI_BVALID, 1'b0);
        check_state("done");
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 id_ready = 1'b1;
            @(negedge clk);
            chk("drain_valid", id_valid, mq.size() != 0);
            chk("drain_level", id_level, mq.size());
            if (mq.size() != 0) begin
                chk("drain_data", id_data, mq[0]);
                void'(mq.pop_front());
            end
        end
        @(posedge clk);
        #1 id_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a, d;
        do_reset();

        // AW and W together to CTRL
        txn(BASE, 32'hA5A5A5A5, 0, 0, 0, 1'b0);
        chk("ctrl_a5", ctrl_reg, 32'hA5A5A5A5);
        // AW first, W three cycles later to ID
        txn(BASE + 32'd4, 32'h1230, 0, 3, 0, 1'b0);
        chk("id_visible", id_valid, 1'b1);
        chk("id_value", id_data, 32'h1230);
        drain(2);
        // W before AW, error addresses
        txn(BASE + 32'hC, 32'h11111111, 2, 0, 1, 1'b0);
        txn(BASE + 32'h10, 32'h22222222, 0, 1, 0, 1'b0);
        txn(BASE + 32'h6, 32'h33333333, 1, 1, 2, 1'b0);
        txn(BASE - 32'h4, 32'h44444444, 0, 0, 0, 1'b0);
        chk("ctrl_unchanged", ctrl_reg, 32'hA5A5A5A5);
        // Overflow: five IDs with consumer stalled
        for (int i = 1; i <= 5; i++) txn(BASE + 32'd4, 32'h100 + 32'(i), 0, 0, 0, 1'b0);
        chk("full_level", id_level, 3'd4);
        chk("ovf_one", ovf_count, 8'd1);
        drain(5);
        // Full FIFO with simultaneous pop in the WRITE cycle
        for (int i = 0; i < 4; i++) txn(BASE + 32'd4, 32'h200 + 32'(i), 0, 0, 0, 1'b0);
        txn(BASE + 32'd4, 32'h204, 1, 0, 0, 1'b1);
        chk("pushpop_level", id_level, 3'd4);
        chk("pushpop_ovf", ovf_count, 8'd1);
        drain(5);

`ifdef AXI_LITE_WR_SLAVE_SEQ_CHECK_EN
        do_reset();
        txn(BASE + 32'd4, 32'h1230, 0, 0, 0, 1'b0);
        txn(BASE + 32'd4, 32'h1231, 0, 0, 0, 1'b0);
        chk("seq_ok", seq_err, 1'b0);
        txn(BASE + 32'd4, 32'h1233, 0, 0, 0, 1'b0);
        chk("seq_set", seq_err, 1'b1);
        txn(BASE, 32'h80000000, 0, 0, 0, 1'b0);
        chk("seq_clr", seq_err, 1'b0);
        chk("ctrl_b31", ctrl_reg, 32'd0);
        drain(4);
`endif

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0:       a = BASE;
                1, 2:    a = BASE + 32'd4;
                3:       a = BASE + 32'd8;
                4:       a = BASE + 32'hC;
                5:       a = BASE + 32'h10 + (32'($urandom_range(0, 15)) << 2);
                6:       a = BASE + 32'($urandom_range(1, 3));
                default: a = BASE - (32'($urandom_range(1, 4)) << 2);
            endcase
            d = $urandom;
            if (a == BASE + 32'd4 && $urandom_range(0, 1) == 1) d = m_last + 32'd1;
            txn(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) drain($urandom_range(1, 4));
        end

        // Reset while address alone is held: no write, no response afterwards
        do_reset();
        @(posedge clk);
        #1 S_AXI_AWADDR = BASE; S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 S_AXI_AWVALID = 1'b0;
        @(negedge clk);
        chk("abandon_awready", S_AXI_AWREADY, 1'b0);
        do_reset();
        @(posedge clk);
        #1 S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WVALID = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 S_AXI_WVALID = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abandon_bvalid", S_AXI_BVALID, 1'b0);
        end
        chk("abandon_ctrl", ctrl_reg, 32'd0);

        // Reset during RESP drops BVALID at once
        do_reset();
        @(posedge clk);
        #1;
        S_AXI_AWADDR = BASE; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h5; S_AXI_WVALID = 1'b1;
        @(posedge clk);
        #1 S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_bvalid", S_AXI_BVALID, 1'b1);
        chk("pre_rst_ctrl", ctrl_reg, 32'h5);
        #2;
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
